// File: rtl/sobel_stream_if.sv
// rtl/sobel_stream_if.sv - pixel-in / gradient-out stream bundle for sobel_stream_engine
interface sobel_stream_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [PIX_W-1:0] in_pix;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pix;

    modport master (
        output in_valid, in_sof, in_pix, mode, out_ready,
        input  in_ready, out_valid, out_pix
    );

    modport slave (
        input  in_valid, in_sof, in_pix, mode, out_ready,
        output in_ready, out_valid, out_pix
    );
endinterface

// File: rtl/sobel_stream_engine.sv
// rtl/sobel_stream_engine.sv - streaming 3x3 Sobel engine, two line buffers, 2-stage pipe
// Optional macro SOBEL_ABS_EN: modes 00/01 output |G| instead of clamping negatives to 0.
module sobel_stream_engine #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64
) (
    input  logic          clk,
    input  logic          rst,
    sobel_stream_if.slave stream
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = 16;
    localparam int GW = PIX_W + 3;
    localparam int SW = PIX_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [SW-1:0] SAT_MAX  = SW'((1 << PIX_W) - 1);

    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [PIX_W-1:0] top_l_q, mid_l_q, bot_l_q;
    logic [PIX_W-1:0] top_m_q, mid_m_q, bot_m_q;
    logic [PIX_W-1:0] top_r, mid_r, bot_r;

    logic [CW-1:0]        col_q, col_d, cur_col;
    logic [RW-1:0]        row_q, row_d, cur_row;
    logic                 mask_d;
    logic signed [GW-1:0] gv_d, gh_d;

    logic                 v1_q, mask1_q;
    logic [1:0]           mode1_q;
    logic signed [GW-1:0] gv_q, gh_q;

    logic signed [GW-1:0] g_sel;
    logic [GW-1:0]        g_mag;
    logic                 out_valid_q;
    logic [PIX_W-1:0]     out_pix_q, out_pix_d;
    logic                 adv, accept;

    function automatic logic signed [GW-1:0] wsum(input logic [PIX_W-1:0] a, b, c);
        return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
    endfunction

    function automatic logic [GW-1:0] mag(input logic signed [GW-1:0] g);
        logic [GW-1:0] r;
        r = g[GW-1] ? -g : g;
        return r;
    endfunction

    function automatic logic [PIX_W-1:0] sat(input logic [SW-1:0] v);
        return (v > SAT_MAX) ? SAT_MAX[PIX_W-1:0] : v[PIX_W-1:0];
    endfunction

    assign adv              = !out_valid_q || stream.out_ready;
    assign accept           = stream.in_valid && adv;
    assign stream.in_ready  = adv;
    assign stream.out_valid = out_valid_q;
    assign stream.out_pix   = out_pix_q;

    // New window column is (lb1, lb0, incoming) = rows r-2, r-1, r at column c.
    always_comb begin
        cur_col = stream.in_sof ? '0 : col_q;
        cur_row = stream.in_sof ? '0 : row_q;
        top_r   = lb1_q[cur_col];
        mid_r   = lb0_q[cur_col];
        bot_r   = stream.in_pix;
        col_d   = (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
        row_d   = cur_row;
        if (cur_col == COL_LAST && cur_row != '1) begin
            row_d = cur_row + 1'b1;
        end
        mask_d  = (cur_row < RW'(2)) || (cur_col < CW'(2));
        gv_d    = wsum(top_r, mid_r, bot_r) - wsum(top_l_q, mid_l_q, bot_l_q);
        gh_d    = wsum(bot_l_q, bot_m_q, bot_r) - wsum(top_l_q, top_m_q, top_r);
    end

    always_comb begin
        g_sel = mode1_q[0] ? gh_q : gv_q;
`ifdef SOBEL_ABS_EN
        g_mag = mag(g_sel);
`else
        g_mag = g_sel[GW-1] ? '0 : g_sel;
`endif
        if (mode1_q[1]) begin
            out_pix_d = sat(SW'(mag(gv_q)) + SW'(mag(gh_q)));
        end else begin
            out_pix_d = sat(SW'(g_mag));
        end
        if (mask1_q) begin
            out_pix_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            v1_q        <= 1'b0;
            mask1_q     <= 1'b1;
            mode1_q     <= '0;
            gv_q        <= '0;
            gh_q        <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
        end else begin
            if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
            end
            if (adv) begin
                v1_q        <= accept;
                mask1_q     <= mask_d;
                mode1_q     <= stream.mode;
                gv_q        <= gv_d;
                gh_q        <= gh_d;
                out_valid_q <= v1_q;
                if (v1_q) begin
                    out_pix_q <= out_pix_d;
                end
            end
        end
    end

    // Line buffers and window are never cleared; border masking hides stale contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_q[cur_col] <= bot_r;
            lb1_q[cur_col] <= mid_r;
            top_l_q        <= top_m_q;
            mid_l_q        <= mid_m_q;
            bot_l_q        <= bot_m_q;
            top_m_q        <= top_r;
            mid_m_q        <= mid_r;
            bot_m_q        <= bot_r;
        end
    end
endmodule

// File: tb/tb_sobel_stream_engine.sv
// tb/tb_sobel_stream_engine.sv - randomized self-checking bench for sobel_stream_engine
module tb_sobel_stream_engine;
    localparam int PIX_W = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
`ifdef SOBEL_ABS_EN
    localparam bit ABS_EN = 1'b1;
`else
    localparam bit ABS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    sobel_stream_if #(.PIX_W(PIX_W)) bus ();
    sobel_stream_engine #(.PIX_W(PIX_W), .IMG_W(IMG_W)) dut (.clk(clk), .rst(rst), .stream(bus));

    always #5 clk = ~clk;

    int img [IMG_H][IMG_W];
    int exp_q[$];
    int got_q[$];
    int checks = 0;
    int failures = 0;
    bit rand_ready = 1'b0;

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) got_q.push_back(int'(bus.out_pix));
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: output for pixel (r,c) is the Sobel response of the window centred at (r-1,c-1).
    function automatic int exp_pix(input int r, input int c, input int m);
        int gv, gh, v;
        if (r < 2 || c < 2) return 0;
        gv = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gh = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        if (m >= 2) begin
            v = iabs(gv) + iabs(gh);
        end else begin
            v = (m == 0) ? gv : gh;
            if (v < 0) v = ABS_EN ? -v : 0;
        end
        return (v > 255) ? 255 : v;
    endfunction

    task automatic load_img(input int kind);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                case (kind)
                    0: img[r][c] = 100;
                    1: img[r][c] = (c < 4) ? 0 : 255;
                    2: img[r][c] = (c < 4) ? 255 : 0;
                    3: img[r][c] = 10 * c;
                    default: img[r][c] = ($urandom_range(0, 3) == 0) ?
                                         (($urandom_range(0, 1) == 1) ? 255 : 0) : $urandom_range(0, 255);
                endcase
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive_pixel(input int r, input int c, input int m, input bit sof);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_pix   = PIX_W'(img[r][c]);
        bus.in_sof   = sof;
        bus.mode     = 2'(m);
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 300) begin
                checks++; failures++;
                $display("FAIL drive_timeout r=%0d c=%0d in_ready=%0b required=1", r, c, bus.in_ready);
                break;
            end
        end
        @(posedge clk);
        exp_q.push_back(exp_pix(r, c, m));
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int mode_sel, input bit gaps);
        int m;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                m = (mode_sel < 0) ? int'($urandom_range(0, 3)) : mode_sel;
                drive_pixel(r, c, m, (r == 0 && c == 0));
                if (gaps && $urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
    endtask

    task automatic drain();
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b required=0", bus.out_valid); end
        checks++;
        if (bus.out_pix !== '0) begin failures++; $display("FAIL reset_out_pix got=%0d required=0", bus.out_pix); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b required=1", bus.in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flat();
        load_img(0);
        for (int m = 0; m < 3; m++) begin
            exp_q.delete(); got_q.delete();
            send_frame(m, 1'b0);
            drain();
            checks++;
            if (got_q.size() !== 64) begin failures++; $display("FAIL flat_count mode=%0d got=%0d required=64", m, got_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL flat mode=%0d idx=%0d got=%0d required=%0d", m, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_edges();
        for (int k = 1; k <= 2; k++) begin
            load_img(k);
            exp_q.delete(); got_q.delete();
            send_frame(0, 1'b0);
            drain();
            checks++;
            if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL edge_count kind=%0d got=%0d required=%0d", k, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL edge kind=%0d idx=%0d got=%0d required=%0d", k, i, got_q[i], exp_q[i]); end
            end
            if (got_q.size() == 64) begin
                checks++;
                if (got_q[20] !== ((k == 1 || ABS_EN) ? 255 : 0)) begin failures++; $display("FAIL edge_centre3 kind=%0d got=%0d", k, got_q[20]); end
                checks++;
                if (got_q[21] !== ((k == 1 || ABS_EN) ? 255 : 0)) begin failures++; $display("FAIL edge_centre4 kind=%0d got=%0d", k, got_q[21]); end
                checks++;
                if (got_q[22] !== 0) begin failures++; $display("FAIL edge_centre5 kind=%0d got=%0d required=0", k, got_q[22]); end
            end
        end
    endtask

    task automatic test_ramp();
        int lit [3] = '{80, 0, 80};
        load_img(3);
        for (int m = 0; m < 3; m++) begin
            exp_q.delete(); got_q.delete();
            send_frame(m, 1'b0);
            drain();
            checks++;
            if (got_q.size() !== 64) begin failures++; $display("FAIL ramp_count mode=%0d got=%0d required=64", m, got_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ramp mode=%0d idx=%0d got=%0d required=%0d", m, i, got_q[i], exp_q[i]); end
            end
            if (got_q.size() > 27) begin
                checks++;
                if (got_q[27] !== lit[m]) begin failures++; $display("FAIL ramp_interior mode=%0d got=%0d required=%0d", m, got_q[27], lit[m]); end
            end
        end
    endtask

    task automatic test_stall();
        logic [PIX_W-1:0] held;
        load_img(3);
        exp_q.delete(); got_q.delete();
        for (int idx = 0; idx < 64; idx++) begin
            if (idx == 28) begin
                bus.in_valid  = 1'b1;
                bus.in_pix    = PIX_W'(img[3][4]);
                bus.in_sof    = 1'b0;
                bus.mode      = 2'd0;
                bus.out_ready = 1'b0;
                held          = '0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 0) held = bus.out_pix;
                    checks++;
                    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%0b required=0", k, bus.in_ready); end
                    checks++;
                    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid cyc=%0d got=%0b required=1", k, bus.out_valid); end
                    if (k > 0) begin
                        checks++;
                        if (bus.out_pix !== held) begin failures++; $display("FAIL stall_out_pix cyc=%0d got=%0d required=%0d", k, bus.out_pix, held); end
                    end
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
            drive_pixel(idx / IMG_W, idx % IMG_W, 0, (idx == 0));
        end
        drain();
        checks++;
        if (got_q.size() !== 64) begin failures++; $display("FAIL stall_count got=%0d required=64", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall idx=%0d got=%0d required=%0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        exp_q.delete(); got_q.delete();
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            load_img(4);
            send_frame(-1, 1'b1);
            drain();
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        checks++;
        if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL random_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL random idx=%0d got=%0d required=%0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        int n_before;
        load_img(1);
        exp_q.delete(); got_q.delete();
        for (int idx = 0; idx < 4 * IMG_W + 3; idx++) drive_pixel(idx / IMG_W, idx % IMG_W, 0, (idx == 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (got_q.size() + 2 !== exp_q.size()) begin failures++; $display("FAIL midreset_retired got=%0d required=%0d", got_q.size(), exp_q.size() - 2); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL midreset_pre idx=%0d got=%0d required=%0d", i, got_q[i], exp_q[i]); end
        end
        n_before = got_q.size();
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_flush out_valid=%0b required=0", bus.out_valid); end
        end
        checks++;
        if (got_q.size() !== n_before) begin failures++; $display("FAIL midreset_leak got=%0d required=%0d", got_q.size(), n_before); end
        @(posedge clk);
        #1;
        exp_q.delete(); got_q.delete();
        send_frame(0, 1'b0);
        drain();
        checks++;
        if (got_q.size() !== 64) begin failures++; $display("FAIL midreset_count got=%0d required=64", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL midreset_post idx=%0d got=%0d required=%0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_pix    = '0;
        bus.mode      = 2'd0;
        bus.out_ready = 1'b1;
        test_reset();
        test_flat();
        test_edges();
        test_ramp();
        test_stall();
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
